// File: rtl/ioctl_stream_writer.sv
// ioctl download driver: paces an upstream byte stream into ioctl_wr strobes
// framed by ioctl_download, with a fixed gap between writes and a closing tail.
module ioctl_stream_writer #(
  parameter int                ADDR_W     = 25,
  parameter int                WR_GAP     = 4,
  parameter int                TAIL       = 8,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] length,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              ioctl_download,
  output logic              ioctl_wr,
  output logic [ADDR_W-1:0] ioctl_addr,
  output logic [7:0]        ioctl_dout,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_WRITE, S_GAP, S_TAIL
  } state_t;

  localparam logic [7:0] GAP_LAST  = 8'(WR_GAP);
  localparam logic [7:0] TAIL_LAST = 8'(TAIL - 1);
  localparam logic       TAIL_ONE  = (TAIL == 1);
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        dout_q, dout_d;
  logic              dl_q, dl_d;
  logic              done_q, done_d;

  // cnt_q counts clocks since the last strobe; it times both gap and tail
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    dl_d    = dl_q;
    done_d  = 1'b0;
    s_ready = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && length != '0) begin
          state_d = S_WAIT;
          rem_d   = length;
          dl_d    = 1'b1;
          addr_d  = START_ADDR;
        end
      end
      S_WAIT: begin
        s_ready = ~abort;
        if (abort) begin
          state_d = S_IDLE;
          dl_d    = 1'b0;
        end else if (s_valid) begin
          dout_d  = s_data;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        rem_d  = rem_q - ONE;
        addr_d = addr_q + ONE;
        cnt_d  = 8'd1;
        if (abort) begin
          state_d = S_IDLE;
          dl_d    = 1'b0;
        end else if (TAIL_ONE && rem_q == ONE) begin
          state_d = S_IDLE;
          dl_d    = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        cnt_d = cnt_q + 8'd1;
        if (abort) begin
          state_d = S_IDLE;
          dl_d    = 1'b0;
        end else if (rem_q == '0 && cnt_q == TAIL_LAST) begin
          state_d = S_IDLE;
          dl_d    = 1'b0;
          done_d  = 1'b1;
        end else if (cnt_q == GAP_LAST) begin
          state_d = (rem_q != '0) ? S_WAIT : S_TAIL;
        end
      end
      S_TAIL: begin
        cnt_d = cnt_q + 8'd1;
        if (abort) begin
          state_d = S_IDLE;
          dl_d    = 1'b0;
        end else if (cnt_q == TAIL_LAST) begin
          state_d = S_IDLE;
          dl_d    = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        dl_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      addr_q  <= START_ADDR;
      cnt_q   <= '0;
      dout_q  <= '0;
      dl_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      dl_q    <= dl_d;
      done_q  <= done_d;
    end
  end

  assign ioctl_download = dl_q;
  assign ioctl_wr       = (state_q == S_WRITE);
  assign ioctl_addr     = addr_q;
  assign ioctl_dout     = dout_q;
  assign busy           = (state_q != S_IDLE);
  assign done           = done_q;

endmodule

// File: tb/tb_ioctl_stream_writer.sv
// Scoreboard bench for ioctl_stream_writer: random payloads and pacing,
// checked against per-byte expectations and timing rules.
module tb_ioctl_stream_writer;

  localparam int AW = 25;
  localparam int GP = 4;
  localparam int TL = 8;
  localparam logic [AW-1:0] SA = '0;

  logic          clk_sys = 1'b0;
  logic          reset_n;
  logic          start, abort, s_valid, s_ready;
  logic [AW-1:0] length;
  logic [7:0]    s_data;
  logic          ioctl_download, ioctl_wr, busy, done;
  logic [AW-1:0] ioctl_addr;
  logic [7:0]    ioctl_dout;

  ioctl_stream_writer #(
    .ADDR_W(AW), .WR_GAP(GP), .TAIL(TL), .START_ADDR(SA)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .start(start),
    .length(length), .abort(abort), .s_valid(s_valid),
    .s_data(s_data), .s_ready(s_ready),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .busy(busy), .done(done)
  );

  always #5 clk_sys = ~clk_sys;

  int tests = 0, fails = 0;
  int cyc = 0;
  int acc_cyc = -100, acc_cnt = 0, last_wr = -1000;
  int nwr = 0, done_seen = 0, exp_done = 0;
  int src_mode = 0;
  bit cont_mode = 1'b0, hold = 1'b0;
  logic [7:0]      src_q[$];
  logic [7:0]      pay[$];
  logic [AW+7:0]   exp_q[$];

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Upstream source: holds a byte valid until it is taken
  initial begin
    s_valid = 1'b0;
    s_data  = 8'h00;
    forever begin
      @(negedge clk_sys);
      if (!hold) begin
        if (src_q.size() > 0 &&
            (src_mode == 0 ||
             (src_mode == 1 && $urandom_range(0, 2) == 0) ||
             (src_mode == 2 && cyc % 10 == 0))) begin
          s_valid = 1'b1;
          s_data  = src_q[0];
          hold    = 1'b1;
        end else begin
          s_valid = 1'b0;
        end
      end
      #4;
      if (s_valid && s_ready) begin
        void'(src_q.pop_front());
        acc_cnt++;
        acc_cyc = cyc;
        hold    = 1'b0;
      end
    end
  end

  // Monitor: every strobe is matched against the scoreboard
  initial begin
    logic [AW+7:0] e;
    forever begin
      @(negedge clk_sys);
      if (!reset_n) continue;
      if (ioctl_wr) begin
        chk("wr_download", ioctl_download, 1);
        chk("wr_after_handshake", cyc - acc_cyc, 1);
        if (cont_mode && nwr > 0)
          chk("wr_spacing", cyc - last_wr, GP + 2);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL wr_unexpected: addr %0h dout %0h, none expected",
                   ioctl_addr, ioctl_dout);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", ioctl_addr, e[AW+7:8]);
          chk("wr_dout", ioctl_dout, e[7:0]);
        end
        nwr++;
        last_wr = cyc;
      end else if (busy && cyc - last_wr >= 1 && cyc - last_wr <= GP) begin
        chk("gap_s_ready", s_ready, 0);
      end
      if (done) begin
        done_seen++;
        chk("done_download", ioctl_download, 0);
        chk("done_delay", cyc - last_wr, TL);
      end
    end
  end

  task automatic flush_src();
    #1;
    src_q.delete();
    hold    = 1'b0;
    s_valid = 1'b0;
  endtask

  task automatic run_dl(input int mode, input bit xstart, input bit xabort);
    int len, n;
    len = pay.size();
    for (int i = 0; i < len; i++) begin
      exp_q.push_back({AW'(SA + AW'(i)), pay[i]});
      src_q.push_back(pay[i]);
    end
    src_mode  = mode;
    cont_mode = (mode == 0);
    nwr       = 0;
    exp_done++;
    @(negedge clk_sys);
    start  = 1'b1;
    length = AW'(len);
    abort  = xabort;
    @(negedge clk_sys);
    start = 1'b0;
    abort = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_download", ioctl_download, 1);
    if (xstart) begin
      repeat (8) @(negedge clk_sys);
      chk("restart_busy", busy, 1);
      start  = 1'b1;
      length = AW'(9);
      @(negedge clk_sys);
      start = 1'b0;
    end
    n = 0;
    while (busy && n < len * 60 + TL + 100) begin
      @(negedge clk_sys);
      n++;
    end
    chk("dl_timeout_busy", busy, 0);
    chk("dl_final_addr", ioctl_addr, AW'(SA + AW'(len)));
    chk("dl_bytes_left", exp_q.size(), 0);
    chk("dl_download_low", ioctl_download, 0);
    pay.delete();
  endtask

  task automatic wait_wr();
    int n;
    n = 0;
    while (!ioctl_wr && n < 60) begin
      @(negedge clk_sys);
      n++;
    end
    chk("wait_wr_timeout", ioctl_wr, 1);
  endtask

  initial begin
    int a0;
    bit bad;
    reset_n = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    length  = '0;
    repeat (3) @(negedge clk_sys);
    chk("rst_download", ioctl_download, 0);
    chk("rst_wr", ioctl_wr, 0);
    chk("rst_addr", ioctl_addr, SA);
    chk("rst_dout", ioctl_dout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset_n = 1'b1;
    @(negedge clk_sys);
    chk("post_rst_ready", s_ready, 0);

    pay = '{8'hA5, 8'h5A, 8'hFF};
    run_dl(0, 1'b0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      int len;
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
      run_dl(k % 2, 1'b0, 1'b0);
    end

    pay = '{8'h11, 8'h22};
    run_dl(2, 1'b0, 1'b0);

    @(negedge clk_sys);
    start  = 1'b1;
    length = '0;
    @(negedge clk_sys);
    start = 1'b0;
    bad   = 1'b0;
    repeat (15) begin
      if (busy || ioctl_download) bad = 1'b1;
      @(negedge clk_sys);
    end
    chk("len0_idle", bad, 0);

    // Abort in the second WAIT_DATA with a byte on offer
    for (int i = 0; i < 3; i++) pay.push_back(8'($urandom));
    exp_q.push_back({SA, pay[0]});
    foreach (pay[i]) src_q.push_back(pay[i]);
    src_mode  = 0;
    cont_mode = 1'b1;
    nwr       = 0;
    a0        = acc_cnt;
    @(negedge clk_sys);
    start  = 1'b1;
    length = AW'(3);
    @(negedge clk_sys);
    start = 1'b0;
    wait_wr();
    repeat (GP + 1) @(negedge clk_sys);
    chk("abort_pre_ready", s_ready, 1);
    abort = 1'b1;
    #1;
    chk("abort_ready", s_ready, 0);
    @(negedge clk_sys);
    abort = 1'b0;
    chk("abort_download", ioctl_download, 0);
    chk("abort_busy", busy, 0);
    repeat (5) @(negedge clk_sys);
    chk("abort_accepted", acc_cnt - a0, 1);
    chk("abort_left", exp_q.size(), 0);
    flush_src();
    pay.delete();

    pay = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_dl(0, 1'b1, 1'b0);
    pay = '{8'hC3, 8'h3C, 8'h99};
    run_dl(0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a gap
    pay = '{8'hDE, 8'hAD, 8'hBE};
    exp_q.push_back({SA, pay[0]});
    foreach (pay[i]) src_q.push_back(pay[i]);
    nwr = 0;
    @(negedge clk_sys);
    start  = 1'b1;
    length = AW'(3);
    @(negedge clk_sys);
    start = 1'b0;
    wait_wr();
    repeat (2) @(negedge clk_sys);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_download", ioctl_download, 0);
    chk("arst_wr", ioctl_wr, 0);
    chk("arst_addr", ioctl_addr, SA);
    chk("arst_dout", ioctl_dout, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", s_ready, 0);
    src_q.delete();
    hold    = 1'b0;
    s_valid = 1'b0;
    exp_q.delete();
    pay.delete();
    @(negedge clk_sys);
    reset_n = 1'b1;
    pay = '{8'h5E, 8'hE5};
    run_dl(0, 1'b0, 1'b0);

    repeat (5) @(negedge clk_sys);
    chk("done_count", done_seen, exp_done);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ioctl_stream_writer.md
Name: ioctl_stream_writer

Overview:
- Drives the ioctl download interface (ioctl_download / ioctl_wr / ioctl_addr / ioctl_dout) that arcade cores consume for ROM loading.
- Sources bytes from an upstream valid/ready byte stream and paces ioctl_wr pulses with a minimum gap.
- Frames the transfer with ioctl_download; cores release their initial reset on its falling edge.
- Used for simulation ROM injection and for on-FPGA loaders that do not go through hps_io.

Parameters:
- ADDR_W, 25: width of ioctl_addr and length.
- WR_GAP, 4: idle clocks after each ioctl_wr pulse before the next byte is accepted; legal range 1..255.
- TAIL, 8: clocks ioctl_download stays high after the final ioctl_wr; legal range 1..255.
- START_ADDR, 0: address of the first byte.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a download; sampled only in IDLE.
- length  in  ADDR_W  byte count, sampled with start.
- abort  in  1  terminates an active download.
- s_valid  in  1  upstream byte valid.
- s_data  in  8  upstream byte.
- s_ready  out  1  block accepts a byte this cycle.
- ioctl_download  out  1  download frame active.
- ioctl_wr  out  1  one-cycle write strobe.
- ioctl_addr  out  ADDR_W  address of the current byte.
- ioctl_dout  out  8  data of the current byte.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse on normal completion.

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0; ioctl_addr = START_ADDR.
- States: IDLE, WAIT_DATA, WRITE, GAP, TAIL.
- IDLE:
  - start=1 and length!=0 → WAIT_DATA next cycle. Latch remaining=length; ioctl_download=1; ioctl_addr=START_ADDR.
  - start with length==0 is ignored: no download, no done pulse.
- WAIT_DATA:
  - s_ready = ~abort.
  - On s_valid & s_ready: ioctl_dout <= s_data; go to WRITE.
- WRITE (exactly 1 cycle):
  - ioctl_wr=1. ioctl_addr and ioctl_dout are stable for the whole cycle.
  - remaining decrements at end of cycle; go to GAP.
- GAP (WR_GAP cycles):
  - ioctl_addr increments by 1 on the first GAP cycle; wrap at 2^ADDR_W.
  - s_ready=0 throughout.
  - Exit to WAIT_DATA if remaining!=0, else TAIL.
- Throughput: with a continuously valid source, ioctl_wr pulses are exactly WR_GAP+2 cycles apart.
- TAIL (TAIL cycles):
  - ioctl_download stays 1, ioctl_wr=0.
  - On exit: ioctl_download=0 and done=1 in the same cycle; state IDLE.
- Final ioctl_addr after a completed download is START_ADDR+length. It is held until the next start.
- abort in WAIT_DATA, GAP or TAIL:
  - Next cycle: state IDLE, ioctl_download=0, no done.
  - A byte presented with s_valid in the abort cycle is not accepted.
- abort in WRITE: the strobe in progress completes; abort takes effect the next cycle (IDLE, download 0).
- start while busy: ignored.
- abort in IDLE: no effect.
- start and abort in the same IDLE cycle: start wins; abort is ignored.
- s_valid held while s_ready=0: data not consumed. Upstream keeps s_data stable until accepted.
- Reset mid-download: outputs drop to 0 immediately, including ioctl_download. Downstream sees a falling edge, which is accepted behaviour.
- ioctl_wr is never asserted while ioctl_download=0.

Test Plan:
- Basic: length=3, bytes A5,5A,FF, s_valid held 1 → exactly 3 ioctl_wr at addr 0,1,2 with dout A5,5A,FF; wr spacing 6 clocks; download falls 8 clocks after last wr, with done=1 in that cycle.
- Backpressure: source valid only every 10 clocks, length=2 → wr only after each handshake; s_ready=0 throughout GAP; addr 0,1.
- length=0 start → no download, busy=0, no done.
- Abort: abort raised during second WAIT_DATA, s_valid=1 in the same cycle → only 1 wr observed (addr 0); download 0 next cycle; no done; s_data not consumed.
- Start while busy and start+abort in IDLE → second start ignored; start+abort begins a download.
- Async reset mid-GAP → all outputs 0 in the same cycle; a fresh start afterwards begins at START_ADDR.
